// File: rtl/mult_fu_pipe_pkg.sv
// mult_fu_pipe_pkg: shared multiply-FU types and rollback rule; MULT_UMULH_EN selects the 128-bit accumulator
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef NUM_PR
`define NUM_PR 64
`endif
package mult_fu_pipe_pkg;
  localparam int ROB_W = $clog2(`NUM_ROB);
  localparam int PR_W = $clog2(`NUM_PR);
`ifdef MULT_UMULH_EN
  localparam int ACC_W = 128;
`else
  localparam int ACC_W = 64;
`endif
  typedef enum logic [1:0] {
    MULQ = 2'd0,
    UMULH = 2'd1,
    MULT_RSV2 = 2'd2,
    MULT_RSV3 = 2'd3
  } MULT_FUNC_t;
  typedef struct packed {
    logic valid;
    MULT_FUNC_t func;
    logic [PR_W-1:0] T_idx;
    logic [ROB_W-1:0] ROB_idx;
    logic [4:0] dest_idx;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [ACC_W-1:0] acc;
  } MULT_STAGE_t;
  localparam MULT_STAGE_t MULT_STAGE_RESET = '0;
  // Younger than the mispredicted branch, counted modulo the ROB size; the branch itself survives.
  function automatic logic rollback_hit(input logic [ROB_W-1:0] idx, input logic [ROB_W-1:0] rb_idx,
                                        input logic [ROB_W-1:0] diff_rob);
    logic [ROB_W-1:0] d;
    d = idx - rb_idx;
    return d != '0 && d <= diff_rob;
  endfunction
endpackage

// File: rtl/mult_fu_pipe_if.sv
// mult_fu_pipe_if: RS issue, rollback and CDB-side signals of the multiply FU
interface mult_fu_pipe_if;
  logic rollback_en;
  logic [mult_fu_pipe_pkg::ROB_W-1:0] ROB_rollback_idx;
  logic [mult_fu_pipe_pkg::ROB_W-1:0] diff_ROB;
  logic issue_valid;
  logic [1:0] issue_func;
  logic [63:0] issue_opa;
  logic [63:0] issue_opb;
  logic [mult_fu_pipe_pkg::PR_W-1:0] issue_T_idx;
  logic [mult_fu_pipe_pkg::ROB_W-1:0] issue_ROB_idx;
  logic [4:0] issue_dest_idx;
  logic issue_ready;
  logic CDB_free;
  logic done;
  logic [mult_fu_pipe_pkg::PR_W-1:0] T_idx;
  logic [mult_fu_pipe_pkg::ROB_W-1:0] ROB_idx;
  logic [4:0] dest_idx;
  logic [63:0] result;
  modport master (
    output rollback_en, ROB_rollback_idx, diff_ROB, issue_valid, issue_func, issue_opa, issue_opb,
           issue_T_idx, issue_ROB_idx, issue_dest_idx, CDB_free,
    input issue_ready, done, T_idx, ROB_idx, dest_idx, result
  );
  modport slave (
    input rollback_en, ROB_rollback_idx, diff_ROB, issue_valid, issue_func, issue_opa, issue_opb,
          issue_T_idx, issue_ROB_idx, issue_dest_idx, CDB_free,
    output issue_ready, done, T_idx, ROB_idx, dest_idx, result
  );
endinterface

// File: rtl/mult_stage.sv
// mult_stage: one partial-product slice; adds opa * opb[W-1:0] << SHIFT and retires W multiplier bits
module mult_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int W = 16,
  parameter int SHIFT = 0
) (
  input MULT_STAGE_t in_e,
  output MULT_STAGE_t out_e
);
  localparam int PP_W = ACC_W < 64 + W ? ACC_W : 64 + W;
  logic [PP_W-1:0] pp;
  always_comb begin
    pp = PP_W'(in_e.opa) * PP_W'(in_e.opb[W-1:0]);
    out_e = in_e;
    out_e.acc = in_e.acc + (ACC_W'(pp) << SHIFT);
    out_e.opb = in_e.opb >> W;
  end
endmodule

// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: elastic NUM_STAGE-deep 64x64 multiply FU feeding the CDB; MULT_UMULH_EN enables UMULH
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int NUM_STAGE = 4
) (
  input logic clock,
  input logic reset,
  mult_fu_pipe_if.slave fu
);
  localparam int W = 64 / NUM_STAGE;
  MULT_STAGE_t s [NUM_STAGE];
  MULT_STAGE_t s_in [NUM_STAGE];
  MULT_STAGE_t s_calc [NUM_STAGE];
  MULT_STAGE_t s_next [NUM_STAGE];
  MULT_STAGE_t last;
  logic [NUM_STAGE-1:0] adv;
  logic issue_fire, issue_kill, fill, kill_in, kill;
  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign s_in[i] = '{valid: 1'b1, func: MULT_FUNC_t'(fu.issue_func), T_idx: fu.issue_T_idx,
                         ROB_idx: fu.issue_ROB_idx, dest_idx: fu.issue_dest_idx,
                         opa: fu.issue_opa, opb: fu.issue_opb, acc: '0};
    end else begin : g_body
      assign s_in[i] = s[i-1];
    end
    mult_stage #(.W(W), .SHIFT(i * W)) u_stage (.in_e(s_in[i]), .out_e(s_calc[i]));
  end
  assign last = s[NUM_STAGE-1];
  // Advance ripples back from the CDB so bubbles collapse while the last stage stalls.
  always_comb begin
    adv = '0;
    adv[NUM_STAGE-1] = last.valid && fu.CDB_free;
    for (int k = NUM_STAGE - 2; k >= 0; k--) adv[k] = s[k].valid && (!s[k+1].valid || adv[k+1]);
  end
  assign fu.issue_ready = !s[0].valid || adv[0];
  assign issue_fire = fu.issue_valid && fu.issue_ready;
  assign issue_kill = fu.rollback_en && rollback_hit(fu.issue_ROB_idx, fu.ROB_rollback_idx, fu.diff_ROB);
  // A squashed entry that moves lands as an empty slot; one that stays is cleared in place.
  always_comb begin
    fill = issue_fire;
    kill_in = issue_kill;
    kill = 1'b0;
    for (int k = 0; k < NUM_STAGE; k++) begin
      kill = fu.rollback_en && rollback_hit(s[k].ROB_idx, fu.ROB_rollback_idx, fu.diff_ROB);
      s_next[k] = fill ? (kill_in ? MULT_STAGE_RESET : s_calc[k]) : (adv[k] || kill ? MULT_STAGE_RESET : s[k]);
      fill = adv[k];
      kill_in = kill;
    end
  end
  always_ff @(posedge clock)
    for (int k = 0; k < NUM_STAGE; k++) s[k] <= reset ? MULT_STAGE_RESET : s_next[k];
  assign fu.done = last.valid;
  assign fu.T_idx = last.T_idx;
  assign fu.ROB_idx = last.ROB_idx;
  assign fu.dest_idx = last.dest_idx;
`ifdef MULT_UMULH_EN
  assign fu.result = last.func == MULQ ? last.acc[63:0] : last.func == UMULH ? last.acc[127:64] : 64'h0;
`else
  assign fu.result = last.func == MULQ ? last.acc : 64'h0;
`endif
endmodule

// File: tb/tb_mult_fu_pipe.sv
// tb_mult_fu_pipe: vector table plus scoreboard for latency, stall, rollback and reset behaviour
module tb_mult_fu_pipe;
  import mult_fu_pipe_pkg::*;
  localparam int NS = 4;
  localparam int NV = 12;
`ifdef MULT_UMULH_EN
  localparam bit UH = 1'b1;
`else
  localparam bit UH = 1'b0;
`endif
  typedef struct {
    logic [1:0] func;
    logic [63:0] a;
    logic [63:0] b;
    int t;
    int rob;
    int dest;
    logic [63:0] res;
  } vec_t;
  typedef struct {
    int t;
    int rob;
    int dest;
    logic [63:0] res;
  } exp_t;
  logic clock, reset;
  int checks, failures, retired, base, ready_low, done_seen;
  exp_t sb[$];
  vec_t v[NV];
  mult_fu_pipe_if bus ();
  mult_fu_pipe #(.NUM_STAGE(NS)) dut (.clock(clock), .reset(reset), .fu(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [63:0] uh(input logic [63:0] x);
    return UH ? x : 64'h0;
  endfunction
  function automatic logic [63:0] model(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'h0, a} * {64'h0, b};
    return f == 2'd0 ? p[63:0] : f == 2'd1 ? uh(p[127:64]) : 64'h0;
  endfunction
  function automatic bit hit(input int rob, input int rb, input int diff);
    int d;
    d = (rob - rb) & ((1 << ROB_W) - 1);
    return d != 0 && d <= diff;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic sb_filter(input int rb, input int diff);
    exp_t keep[$];
    foreach (sb[i]) if (!hit(sb[i].rob, rb, diff)) keep.push_back(sb[i]);
    sb = keep;
  endtask
  task automatic issue(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic [63:0] res,
                       input int t, input int rob, input int dest, input bit rb, input int rb_idx, input int rb_diff);
    bit ok;
    exp_t e;
    ok = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_func = f;
    bus.issue_opa = a;
    bus.issue_opb = b;
    bus.issue_T_idx = PR_W'(t);
    bus.issue_ROB_idx = ROB_W'(rob);
    bus.issue_dest_idx = 5'(dest);
    bus.rollback_en = rb;
    bus.ROB_rollback_idx = ROB_W'(rb_idx);
    bus.diff_ROB = ROB_W'(rb_diff);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      if (rb) sb_filter(rb_idx, rb_diff);
      if (bus.issue_ready) begin
        ok = 1'b1;
        e.t = t;
        e.rob = rob;
        e.dest = dest;
        e.res = res;
        if (!(rb && hit(rob, rb_idx, rb_diff))) sb.push_back(e);
      end
      @(posedge clock);
      #1;
    end
    bus.issue_valid = 1'b0;
    bus.rollback_en = 1'b0;
    chk("issue_accepted", ok, 1'b1);
  endtask
  task automatic rollback(input int rb_idx, input int rb_diff);
    bus.rollback_en = 1'b1;
    bus.ROB_rollback_idx = ROB_W'(rb_idx);
    bus.diff_ROB = ROB_W'(rb_diff);
    @(negedge clock);
    sb_filter(rb_idx, rb_diff);
    @(posedge clock);
    #1;
    bus.rollback_en = 1'b0;
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.done) && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk(name, sb.size(), 0);
  endtask
  // Scoreboard: every CDB hand-off must match the oldest surviving issue.
  always @(negedge clock) begin
    if (!reset && bus.done && bus.CDB_free) begin
      retired++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL retire_unexpected: got ROB %0d T %0d, required no completion", bus.ROB_idx, bus.T_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.T_idx !== PR_W'(e.t) || bus.ROB_idx !== ROB_W'(e.rob) || bus.dest_idx !== 5'(e.dest) ||
            bus.result !== e.res) begin
          failures++;
          $display("FAIL retire_data: got T %0d ROB %0d dest %0d res %0h, required T %0d ROB %0d dest %0d res %0h",
                   bus.T_idx, bus.ROB_idx, bus.dest_idx, bus.result, e.t, e.rob, e.dest, e.res);
        end
      end
    end
  end
  initial begin
    checks = 0;
    failures = 0;
    retired = 0;
    v[0] = '{2'd0, 64'd3, 64'd5, 7, 4, 3, 64'd15};
    v[1] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8, 5, 4, uh(64'h1)};
    v[2] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 9, 6, 5, 64'hFFFF_FFFF_FFFF_FFFE};
    v[3] = '{2'd0, 64'h1_0000_0000, 64'h1_0000_0000, 10, 7, 6, 64'h0};
    v[4] = '{2'd1, 64'h1_0000_0000, 64'h1_0000_0000, 11, 8, 7, uh(64'h1)};
    v[5] = '{2'd0, 64'h1234_5678, 64'h10, 12, 9, 8, 64'h1_2345_6780};
    v[6] = '{2'd2, 64'd7, 64'd9, 13, 10, 9, 64'h0};
    v[7] = '{2'd3, 64'hFFFF, 64'hFFFF, 14, 11, 10, 64'h0};
    v[8] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 15, 12, 11, 64'h1};
    v[9] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16, 13, 12, uh(64'hFFFF_FFFF_FFFF_FFFE)};
    v[10] = '{2'd1, 64'h8000_0000_0000_0000, 64'd3, 17, 14, 13, uh(64'h1)};
    v[11] = '{2'd0, 64'h8000_0000_0000_0000, 64'd3, 18, 15, 14, 64'h8000_0000_0000_0000};
    reset = 1'b1;
    bus.rollback_en = 1'b0;
    bus.ROB_rollback_idx = '0;
    bus.diff_ROB = '0;
    bus.issue_valid = 1'b0;
    bus.issue_func = 2'd0;
    bus.issue_opa = 64'h0;
    bus.issue_opb = 64'h0;
    bus.issue_T_idx = '0;
    bus.issue_ROB_idx = '0;
    bus.issue_dest_idx = '0;
    bus.CDB_free = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_ready", bus.issue_ready, 1'b1);
    chk("reset_T_idx", bus.T_idx, 0);
    chk("reset_result", bus.result, 64'h0);
    @(posedge clock);
    #1;
    // Isolated ops: fixed latency, one-cycle done pulse, data checked by the scoreboard.
    for (int i = 0; i < NV; i++) begin
      int n;
      issue(v[i].func, v[i].a, v[i].b, v[i].res, v[i].t, v[i].rob, v[i].dest, 1'b0, 0, 0);
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!bus.done && n < 20);
      chk("latency", n, NS);
      @(negedge clock);
      chk("done_pulse", bus.done, 1'b0);
      @(posedge clock);
      #1;
    end
    chk("table_retired", retired, NV);
    // Back-to-back issue with a four-cycle CDB stall.
    base = retired;
    ready_low = 0;
    fork
      for (int i = 0; i < 6; i++) begin
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        issue(2'(i % 2), a, b, model(2'(i % 2), a, b), 20 + i, i + 1, i, 1'b0, 0, 0);
      end
      begin
        repeat (5) @(posedge clock);
        #1 bus.CDB_free = 1'b0;
        repeat (4) begin
          @(negedge clock);
          if (!bus.issue_ready) ready_low++;
          chk("stall_done", bus.done, 1'b1);
          chk("stall_T_idx", bus.T_idx, sb.size() != 0 ? PR_W'(sb[0].t) : '1);
          chk("stall_result", bus.result, sb.size() != 0 ? sb[0].res : 64'hX);
          @(posedge clock);
        end
        #1 bus.CDB_free = 1'b1;
      end
    join
    drain("stream_drain");
    chk("stream_ready_dropped", ready_low != 0, 1'b1);
    chk("stream_retired", retired - base, 6);
    // Rollback of ROB 10 with diff 5 over in-flight 10/12/15/20.
    @(posedge clock);
    #1 bus.CDB_free = 1'b0;
    base = retired;
    issue(2'd0, 64'd10, 64'd10, 64'd100, 30, 10, 1, 1'b0, 0, 0);
    issue(2'd0, 64'd12, 64'd12, 64'd144, 31, 12, 2, 1'b0, 0, 0);
    issue(2'd0, 64'd15, 64'd15, 64'd225, 32, 15, 3, 1'b0, 0, 0);
    issue(2'd0, 64'd20, 64'd20, 64'd400, 33, 20, 4, 1'b0, 0, 0);
    @(negedge clock);
    chk("full_ready", bus.issue_ready, 1'b0);
    @(posedge clock);
    #1;
    rollback(10, 5);
    chk("rb_sb_kept", sb.size(), 2);
    bus.CDB_free = 1'b1;
    drain("rb_drain");
    chk("rb_retired", retired - base, 2);
    // Wrapped rollback of ROB 30 with diff 4; ROB 1 arrives in the rollback cycle itself.
    @(posedge clock);
    #1 bus.CDB_free = 1'b0;
    base = retired;
    issue(2'd0, 64'd31, 64'd2, 64'd62, 40, 31, 5, 1'b0, 0, 0);
    issue(2'd0, 64'd3, 64'd2, 64'd6, 41, 3, 6, 1'b0, 0, 0);
    issue(2'd0, 64'd1, 64'd2, 64'd2, 42, 1, 7, 1'b1, 30, 4);
    chk("wrap_sb_kept", sb.size(), 1);
    bus.CDB_free = 1'b1;
    drain("wrap_drain");
    chk("wrap_retired", retired - base, 1);
    // Reset with a full pipeline: nothing may complete afterwards.
    @(posedge clock);
    #1 bus.CDB_free = 1'b0;
    for (int i = 0; i < 4; i++) issue(2'd0, 64'(i + 2), 64'd3, 64'(3 * (i + 2)), 50 + i, 1 + i, i, 1'b0, 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    bus.CDB_free = 1'b1;
    @(negedge clock);
    chk("mid_reset_done", bus.done, 1'b0);
    chk("mid_reset_ready", bus.issue_ready, 1'b1);
    base = retired;
    done_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.done) done_seen++;
    end
    chk("mid_reset_no_done", done_seen, 0);
    chk("mid_reset_retired", retired - base, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
